// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, issues word reads and buffers returns for decode.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module inst_prefetch #(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [31:0] INST_NOP = 32'h0000_0001;
  localparam logic [CW:0] CREDITS  = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic        head_vld;
  logic        pending;
  logic        grant;
  logic        ret;
  logic        ret_keep;
  logic        pop;
  logic [CW:0] used;

  // cnt_q counts only returned entries; in-flight reads (kept or dropped) are charged via outst_q.
  always_comb begin
    head_vld     = cnt_q != '0;
    pending      = outst_q != drop_q;
    used         = {1'b0, cnt_q} + {1'b0, outst_q};
    ibus_req_o   = !jump_flag_i && (used < CREDITS);
    ibus_addr_o  = pc_q;
    grant        = ibus_req_o && ibus_gnt_i;
    ret          = ibus_rvalid_i && (outst_q != '0);
    ret_keep     = ret && (drop_q == '0) && !jump_flag_i;
    pop          = head_vld && !hold_flag_i && !jump_flag_i;
    inst_valid_o = head_vld;
    inst_o       = head_vld ? inst_mem[rd_ptr_q] : INST_NOP;
    // With no returned entry the head slot, if reserved, is the oldest pending fetch.
    inst_addr_o  = (head_vld || pending) ? addr_mem[rd_ptr_q] : pc_q;
  end

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    fill_ptr_d = fill_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (jump_flag_i) begin
      pc_d       = {jump_addr_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      fill_ptr_d = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      outst_d    = outst_q - CW'(ret);
      drop_d     = outst_q - CW'(ret);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      fill_ptr_d = fill_ptr_q + AW'(ret_keep);
      wr_ptr_d   = wr_ptr_q + AW'(grant);
      cnt_d      = cnt_q + CW'(ret_keep) - CW'(pop);
      outst_d    = outst_q + CW'(grant) - CW'(ret);
      if (ret && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      rd_ptr_q   <= '0;
      fill_ptr_q <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      addr_mem[wr_ptr_q] <= pc_q;
    end
    if (ret_keep) begin
      inst_mem[fill_ptr_q] <= ibus_rdata_i;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'(pop);
      perf_flush_cnt_o <= perf_flush_cnt_o + 32'(jump_flag_i);
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomised bench for inst_prefetch with a queue-based reference model and a simple in-order bus model.
module tb_inst_prefetch;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_A = 32'h0;
  localparam logic [31:0] NOP   = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        hold;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  always #5 clk = ~clk;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_flag_i(hold),
    .ibus_req_o(ibus_req), .ibus_addr_o(ibus_addr), .ibus_gnt_i(gnt),
    .ibus_rvalid_i(rvalid), .ibus_rdata_i(rdata),
    .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_flush_cnt_o(perf_flush)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  typedef struct { logic [31:0] a; int unsigned rdy; } bq_t;

  // Reference model: returned entries, kept pending addresses, in-flight and drop counts.
  ent_t        m_fill[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_pc;
  int          m_outst, m_drop;
  int unsigned m_pops;
  logic [31:0] m_pf, m_pfl;

  bq_t         bq[$];
  int unsigned cyc, gnt_pct, lat_lo, lat_hi;
  bit          ret_en;

  logic [31:0] pop_log[$];
  logic [31:0] pop_dat[$];
  int unsigned first_valid_cyc;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fill.delete(); m_pend.delete();
    m_pc = RST_A; m_outst = 0; m_drop = 0; m_pops = 0; m_pf = '0; m_pfl = '0;
    bq.delete(); cyc = 0; pop_log.delete(); pop_dat.delete(); first_valid_cyc = 0;
  endtask

  task automatic compare_and_update();
    logic        e_valid, e_req, ret, grant;
    logic [31:0] e_inst, e_iaddr;
    bq_t         b;
    ent_t        e;
    e_valid = m_fill.size() > 0;
    e_req   = !jump_flag && ((m_fill.size() + m_outst) < DEPTH);
    e_inst  = e_valid ? m_fill[0].d : NOP;
    e_iaddr = e_valid ? m_fill[0].a : (m_pend.size() > 0 ? m_pend[0] : m_pc);
    check("ibus_req", ibus_req, e_req);
    check("ibus_addr", ibus_addr, m_pc);
    check("inst_valid", inst_valid, e_valid);
    check("inst", inst, e_inst);
    check("inst_addr", inst_addr, e_iaddr);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch, m_pf);
    check("perf_flush", perf_flush, m_pfl);
`endif
    if (rvalid) check("rvalid_with_outstanding", m_outst > 0, 1'b1);
    s_req = ibus_req; s_valid = inst_valid; s_addr = ibus_addr;
    if (inst_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
    if (inst_valid && !hold && !jump_flag) begin
      pop_log.push_back(inst_addr);
      pop_dat.push_back(inst);
    end
    if (rvalid) void'(bq.pop_front());
    if (ibus_req && gnt) begin
      b.a = ibus_addr; b.rdy = cyc + 1 + $urandom_range(lat_lo, lat_hi);
      bq.push_back(b);
    end
    ret   = rvalid && (m_outst > 0);
    grant = e_req && gnt;
    if (jump_flag) begin
      m_pfl++;
      m_fill.delete(); m_pend.delete();
      if (ret) m_outst--;
      m_drop = m_outst;
      m_pc = {jump_addr[31:2], 2'b00};
    end else begin
      if (e_valid && !hold) begin
        void'(m_fill.pop_front());
        m_pops++; m_pf++;
      end
      if (ret) begin
        m_outst--;
        if (m_drop > 0) m_drop--;
        else if (m_pend.size() > 0) begin
          e.a = m_pend.pop_front(); e.d = rdata;
          m_fill.push_back(e);
        end
      end
      if (grant) begin
        m_pend.push_back(m_pc);
        m_pc += 32'd4;
        m_outst++;
      end
    end
  endtask

  task automatic tick(input logic h, input logic j, input logic [31:0] ja);
    hold = h; jump_flag = j; jump_addr = ja;
    cyc++;
    gnt = ($urandom_range(0, 99) < gnt_pct);
    if (ret_en && bq.size() > 0 && bq[0].rdy <= cyc) begin
      rvalid = 1'b1; rdata = bus_data(bq[0].a);
    end else begin
      rvalid = 1'b0; rdata = $urandom;
    end
    @(negedge clk);
    compare_and_update();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must reach reset values without any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b0; jump_flag = 1'b0; hold = 1'b0; jump_addr = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    #1;
    check("rst_ibus_req", ibus_req, 1'b1);
    check("rst_ibus_addr", ibus_addr, RST_A);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, NOP);
    check("rst_inst_addr", inst_addr, RST_A);
`ifdef IFU_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch, 32'd0);
    check("rst_perf_flush", perf_flush, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k, p0, rand_pops;
    bit mid_done;
    rst = 1'b1;
    gnt_pct = 100; lat_lo = 0; lat_hi = 0; ret_en = 1'b1;

    // Zero-wait bus straight after reset.
    do_reset();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0);
    check("first_valid_cycle", first_valid_cyc, 32'd3);
    if (pop_log.size() < 4) check("stream_len", pop_log.size(), 32'd4);
    else for (int i = 0; i < 4; i++) check("stream_addr", pop_log[i], 32'(i * 4));

    // Hold three cycles: buffer fills to DEPTH and requests stop.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
    check("hold_req_low", s_req, 1'b0);
    check("hold_head_valid", s_valid, 1'b1);
    check("hold_model_fill", m_fill.size(), 32'd2);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);
    for (int i = 1; i < pop_log.size(); i++) check("hold_stream_seq", pop_log[i], pop_log[i-1] + 32'd4);

    // Jump with two reads outstanding: both stale returns must be dropped.
    do_reset();
    ret_en = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h100);
    check("jump_model_drop", m_drop, 32'd2);
    ret_en = 1'b1;
    k = 0;
    while (pop_log.size() == 0 && k < 50) begin tick(1'b0, 1'b0, 32'h0); k++; end
    if (pop_log.size() == 0) check("jump100_timeout", 32'd0, 32'd1);
    else begin
      check("jump100_addr", pop_log[0], 32'h100);
      check("jump100_data", pop_dat[0], 32'hEDCB_A887);
    end

    // Unaligned target is word aligned.
    pop_log.delete(); pop_dat.delete();
    tick(1'b0, 1'b1, 32'h203);
    tick(1'b0, 1'b0, 32'h0);
    check("jump203_ibus_addr", s_addr, 32'h200);
    k = 0;
    while (pop_log.size() == 0 && k < 50) begin tick(1'b0, 1'b0, 32'h0); k++; end
    if (pop_log.size() == 0) check("jump203_timeout", 32'd0, 32'd1);
    else check("jump203_addr", pop_log[0], 32'h200);

`ifdef IFU_PERF_CNT_EN
    do_reset();
    k = 0;
    while (m_pops < 10 && k < 200) begin tick(1'b0, 1'b0, 32'h0); k++; end
    tick(1'b1, 1'b1, 32'h40);
    tick(1'b1, 1'b1, 32'h80);
    check("perf_fetch_10", perf_fetch, 32'd10);
    check("perf_flush_2", perf_flush, 32'd2);
    do_reset();
`endif

    // Random bus delays, holds and flushes, with one asynchronous reset mid-run.
    do_reset();
    gnt_pct = 60; lat_lo = 0; lat_hi = 4;
    rand_pops = 0; mid_done = 1'b0; k = 0;
    while (rand_pops < 1000 && k < 40000) begin
      p0 = m_pops;
      tick($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 2, $urandom);
      rand_pops += m_pops - p0;
      k++;
      if (!mid_done && rand_pops >= 500) begin
        mid_done = 1'b1;
        do_reset();
      end
    end
    check("random_pops_done", rand_pops >= 1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
